// File: rtl/reel_spinner.sv
// Three decimal reels stepped on a divided clock and stopped one at a time
// by a synchronised, debounced player button; feeds the digit display path.
module reel_spinner #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       spinning,
    output logic       done,
    output logic       round_end
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned SUM_W = DIG_W + 1;
    localparam int unsigned PRE_W = $clog2(DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE);
    localparam logic [DIG_W-1:0] STEP1   = DIG_W'(1);
    localparam logic [DIG_W-1:0] STEP2   = DIG_W'(3);
    localparam logic [DIG_W-1:0] STEP3   = DIG_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPIN_ALL = 3'd1,
        ST_SPIN_23  = 3'd2,
        ST_SPIN_3   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic [DB_W-1:0]   w_db_cnt_nxt;
    logic              r_db_lvl;
    logic              r_db_lvl_d;
    logic              w_press;

    logic [PRE_W-1:0]  r_pre;
    logic [PRE_W-1:0]  w_pre_nxt;
    logic              w_spin_cur;
    logic              w_tick;

    logic              w_run1;
    logic              w_run2;
    logic              w_run3;
    logic              w_spin_nxt;
    logic              w_done_nxt;
    logic              w_round_end_nxt;

    logic [DIG_W-1:0]  r_digit1;
    logic [DIG_W-1:0]  r_digit2;
    logic [DIG_W-1:0]  r_digit3;
    logic              r_spinning;
    logic              r_done;
    logic              r_round_end;

    // Mod-10 add of a BCD digit and a step below 10
    function automatic logic [DIG_W-1:0] bcd_step(input logic [DIG_W-1:0] d,
                                                  input logic [DIG_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, d} + {1'b0, inc};
        if (sum >= SUM_W'(10)) begin
            sum = sum - SUM_W'(10);
        end
        return sum[DIG_W-1:0];
    endfunction

    // Debounce counter saturates so a long hold never wraps into a second press
    always_comb begin
        w_db_cnt_nxt = '0;
        if (r_sync2) begin
            w_db_cnt_nxt = (r_db_cnt == DB_MAX) ? r_db_cnt : r_db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_db_lvl   <= 1'b0;
            r_db_lvl_d <= 1'b0;
        end else begin
            r_sync1    <= in;
            r_sync2    <= r_sync1;
            r_db_cnt   <= w_db_cnt_nxt;
            r_db_lvl   <= r_sync2 & (r_db_lvl | (w_db_cnt_nxt == DB_MAX));
            r_db_lvl_d <= r_db_lvl;
        end
    end

    assign w_press = r_db_lvl & ~r_db_lvl_d;

    assign w_spin_cur = (r_state == ST_SPIN_ALL) || (r_state == ST_SPIN_23) ||
                        (r_state == ST_SPIN_3);
    assign w_tick     = w_spin_cur && (r_pre == PRE_MAX);

    // Next state plus reel-run enables taken from the next state, so a reel
    // being stopped on a tick cycle does not advance
    always_comb begin
        w_state_nxt     = r_state;
        w_run1          = 1'b0;
        w_run2          = 1'b0;
        w_run3          = 1'b0;
        w_spin_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_round_end_nxt = 1'b0;

        case (r_state)
            ST_IDLE:     if (w_press) w_state_nxt = ST_SPIN_ALL;
            ST_SPIN_ALL: if (w_press) w_state_nxt = ST_SPIN_23;
            ST_SPIN_23:  if (w_press) w_state_nxt = ST_SPIN_3;
            ST_SPIN_3:   if (w_press) w_state_nxt = ST_DONE;
            ST_DONE:     if (w_press) w_state_nxt = ST_SPIN_ALL;
            default:     w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_SPIN_ALL: begin
                w_run1     = 1'b1;
                w_run2     = 1'b1;
                w_run3     = 1'b1;
                w_spin_nxt = 1'b1;
            end
            ST_SPIN_23: begin
                w_run2     = 1'b1;
                w_run3     = 1'b1;
                w_spin_nxt = 1'b1;
            end
            ST_SPIN_3: begin
                w_run3     = 1'b1;
                w_spin_nxt = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt      = 1'b1;
                w_round_end_nxt = (r_state == ST_SPIN_3);
            end
            default: ;
        endcase
    end

    // Prescaler restarts on every entry to SPIN_ALL and idles outside spin states
    always_comb begin
        w_pre_nxt = '0;
        if ((w_state_nxt == ST_SPIN_ALL) && (r_state != ST_SPIN_ALL)) begin
            w_pre_nxt = '0;
        end else if (w_spin_cur) begin
            w_pre_nxt = w_tick ? '0 : r_pre + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pre       <= '0;
            r_digit1    <= '0;
            r_digit2    <= '0;
            r_digit3    <= '0;
            r_spinning  <= 1'b0;
            r_done      <= 1'b0;
            r_round_end <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre       <= w_pre_nxt;
            r_spinning  <= w_spin_nxt;
            r_done      <= w_done_nxt;
            r_round_end <= w_round_end_nxt;
            if (w_tick && w_run1) r_digit1 <= bcd_step(r_digit1, STEP1);
            if (w_tick && w_run2) r_digit2 <= bcd_step(r_digit2, STEP2);
            if (w_tick && w_run3) r_digit3 <= bcd_step(r_digit3, STEP3);
        end
    end

    assign digit1    = r_digit1;
    assign digit2    = r_digit2;
    assign digit3    = r_digit3;
    assign spinning  = r_spinning;
    assign done      = r_done;
    assign round_end = r_round_end;

endmodule

// File: tb/tb_reel_spinner.sv
// Directed bench for reel_spinner (DIV=4, DEBOUNCE=3); edge counts in the
// comments are posedges since the button was last raised.
module tb_reel_spinner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic        spinning;
    logic        done;
    logic        round_end;
    logic [11:0] digits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reel_spinner #(.DIV(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .spinning  (spinning),
        .done      (done),
        .round_end (round_end)
    );

    assign digits = {digit1, digit2, digit3};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_release();
        in = 1'b1;
        step(6);
        in = 1'b0;
        step(6);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (digits !== 12'h000) begin errors++; $display("FAIL reset_digits got %h expected 000", digits); end
        checks++; if (spinning !== 1'b0) begin errors++; $display("FAIL reset_spinning got %b expected 0", spinning); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (round_end !== 1'b0) begin errors++; $display("FAIL reset_round_end got %b expected 0", round_end); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_short_pulse();
        in = 1'b1;
        step(2);
        in = 1'b0;
        step(8);
        checks++; if (spinning !== 1'b0) begin errors++; $display("FAIL glitch_spinning got %b expected 0", spinning); end
        checks++; if (digits !== 12'h000) begin errors++; $display("FAIL glitch_digits got %h expected 000", digits); end
        checks++; if (done !== 1'b0 || round_end !== 1'b0) begin errors++; $display("FAIL glitch_done got %b%b expected 00", done, round_end); end
    endtask

    task automatic test_start_and_hold();
        in = 1'b1;
        step(5);
        checks++; if (spinning !== 1'b0) begin errors++; $display("FAIL start_early got %b expected 0", spinning); end
        step(1);
        checks++; if (spinning !== 1'b1) begin errors++; $display("FAIL start_edge6 got %b expected 1", spinning); end
        checks++; if (digits !== 12'h000) begin errors++; $display("FAIL start_digits got %h expected 000", digits); end
        step(16);
        checks++; if (digits !== 12'h428) begin errors++; $display("FAIL spin_16 got %h expected 428", digits); end
        // edge 50: eleven ticks with all reels running, so no second press
        step(28);
        checks++; if (digits !== 12'h137) begin errors++; $display("FAIL hold_50 got %h expected 137", digits); end
        checks++; if (spinning !== 1'b1) begin errors++; $display("FAIL hold_spinning got %b expected 1", spinning); end
        in = 1'b0;
        step(10);
    endtask

    task automatic test_stop_sequence();
        // press on edge 66 coincides with a tick: reel 1 frozen at 4
        press_release();
        checks++; if (digits !== 12'h482) begin errors++; $display("FAIL stop1 got %h expected 482", digits); end
        press_release();
        checks++; if (digits !== 12'h413) begin errors++; $display("FAIL stop2 got %h expected 413", digits); end
        in = 1'b1;
        step(5);
        checks++; if (done !== 1'b0 || round_end !== 1'b0) begin errors++; $display("FAIL pre_done got %b%b expected 00", done, round_end); end
        step(1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_set got %b expected 1", done); end
        checks++; if (round_end !== 1'b1) begin errors++; $display("FAIL round_end_pulse got %b expected 1", round_end); end
        checks++; if (spinning !== 1'b0) begin errors++; $display("FAIL done_spinning got %b expected 0", spinning); end
        checks++; if (digits !== 12'h410) begin errors++; $display("FAIL done_digits got %h expected 410", digits); end
        step(1);
        checks++; if (round_end !== 1'b0) begin errors++; $display("FAIL round_end_width got %b expected 0", round_end); end
        in = 1'b0;
        step(100);
        checks++; if (digits !== 12'h410) begin errors++; $display("FAIL done_hold got %h expected 410", digits); end
        checks++; if (done !== 1'b1 || spinning !== 1'b0) begin errors++; $display("FAIL done_hold_flags got %b%b expected 10", done, spinning); end
        in = 1'b1;
        step(6);
        checks++; if (spinning !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL new_round got %b%b expected 10", spinning, done); end
        step(4);
        checks++; if (digits !== 12'h547) begin errors++; $display("FAIL new_round_tick got %h expected 547", digits); end
        in = 1'b0;
        step(6);
    endtask

    task automatic test_press_on_tick();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        in = 1'b1;
        step(5);
        in = 1'b0;
        step(3);
        // second press lands in the tick cycle before edge 14
        in = 1'b1;
        step(2);
        checks++; if (digits !== 12'h137) begin errors++; $display("FAIL align_pre got %h expected 137", digits); end
        step(3);
        checks++; if (digits !== 12'h137 || spinning !== 1'b1) begin errors++; $display("FAIL align_hold got %h/%b expected 137/1", digits, spinning); end
        step(1);
        checks++; if (digits !== 12'h164) begin errors++; $display("FAIL align_edge got %h expected 164", digits); end
        step(4);
        checks++; if (digits !== 12'h191) begin errors++; $display("FAIL spin23_tick got %h expected 191", digits); end
    endtask

    task automatic test_async_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (digits !== 12'h000) begin errors++; $display("FAIL async_digits got %h expected 000", digits); end
        checks++; if (spinning !== 1'b0 || done !== 1'b0 || round_end !== 1'b0) begin errors++; $display("FAIL async_flags got %b%b%b expected 000", spinning, done, round_end); end
        in = 1'b0;
        #1 rst_n = 1'b1;
        step(2);
        checks++; if (digits !== 12'h000 || spinning !== 1'b0) begin errors++; $display("FAIL post_reset got %h/%b expected 000/0", digits, spinning); end
        in = 1'b1;
        step(5);
        checks++; if (spinning !== 1'b0) begin errors++; $display("FAIL idle_early got %b expected 0", spinning); end
        step(1);
        checks++; if (spinning !== 1'b1) begin errors++; $display("FAIL idle_start got %b expected 1", spinning); end
        step(4);
        checks++; if (digits !== 12'h137) begin errors++; $display("FAIL idle_spin_all got %h expected 137", digits); end
        in = 1'b0;
        step(6);
    endtask

    initial begin
        test_reset();
        test_short_pulse();
        test_start_and_hold();
        test_stop_sequence();
        test_press_on_tick();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
